// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the slide-switch debouncer.
//   SW_WIDTH                - number of board slide switches
//   DEFAULT_DEBOUNCE_CYCLES - 10 ms at 50 MHz
//   db_state_e              - per-bit state: IDLE (agrees) / PENDING (change counting)
package sw_pkg;

    localparam int SW_WIDTH                = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// debounce_bit: one switch channel.
//   clk, rst_n - clock, async active-low reset
//   sw         - raw asynchronous switch level
//   clean      - debounced level
//   rise, fall - one-cycle pulses coinciding with the first cycle of a new clean level
//   pending    - sampled level currently disagrees with clean
module debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter holds the number of disagreeing cycles already seen; the
    // cycle that would bring it to DEBOUNCE_CYCLES accepts the change
    // instead, so it never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          clean_nxt, rise_nxt, fall_nxt;
    db_state_e     state;

    assign state   = (sync2 != clean) ? PENDING : IDLE;
    assign pending = (state == PENDING);

    always_comb begin
        cnt_nxt   = '0;
        clean_nxt = clean;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (state == PENDING) begin
            if (cnt == LAST) begin
                clean_nxt = sync2;
                rise_nxt  = sync2;
                fall_nxt  = ~sync2;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: WIDTH independent switch debouncers plus an all-idle flag.
//   CLOCK_50 - clock
//   RESET_N  - async active-low reset
//   SW       - raw bouncing switch levels
//   SW_CLEAN - debounced levels
//   SW_RISE  - per-bit 0->1 pulse on SW_CLEAN
//   SW_FALL  - per-bit 1->0 pulse on SW_CLEAN
//   STABLE   - registered: no channel had a change pending last cycle
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_CLEAN,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             STABLE
);

    logic [WIDTH-1:0] pending;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (CLOCK_50),
            .rst_n  (RESET_N),
            .sw     (SW[i]),
            .clean  (SW_CLEAN[i]),
            .rise   (SW_RISE[i]),
            .fall   (SW_FALL[i]),
            .pending(pending[i])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) STABLE <= 1'b1;
        else          STABLE <= ~|pending;
    end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int HN = 8192;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw    = '0;
    logic [W-1:0] clean, rise, fall;
    logic         stable;
    logic [W-1:0] sw1   = '0;
    logic [W-1:0] clean1, rise1, fall1;
    logic         stable1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw),
        .SW_CLEAN(clean), .SW_RISE(rise), .SW_FALL(fall), .STABLE(stable)
    );

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw1),
        .SW_CLEAN(clean1), .SW_RISE(rise1), .SW_FALL(fall1), .STABLE(stable1)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raws[j] = raw SW seen at the j-th edge after reset release. The level
    // the debouncer judges after edge k is the raw value two edges back.
    // A bit flips at edge n iff the judged level disagreed with clean on each
    // of the D cycles before edge n and none of those cycles precede its
    // previous flip.
    logic [W-1:0] raws [HN];
    int           n;
    int           last_chg [W];
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_stable;

    function automatic logic [W-1:0] sval(input int k);
        if (k < 1) return '0;
        return raws[(k - 1) % HN];
    endfunction

    task automatic model_reset();
        n        = 0;
        m_clean  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_stable = 1'b1;
        for (int b = 0; b < W; b++) last_chg[b] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] nc, sk;
        bit           ok;
        m_stable = ((sval(n - 1) ^ m_clean) == '0);
        nc = m_clean;
        for (int b = 0; b < W; b++) begin
            ok = (n - D >= last_chg[b]);
            for (int k = n - D; k < n; k++) begin
                sk = sval(k);
                if (ok && sk[b] == m_clean[b]) ok = 0;
            end
            if (ok) begin
                nc[b]       = ~m_clean[b];
                last_chg[b] = n;
            end
        end
        m_rise  = nc & ~m_clean;
        m_fall  = ~nc & m_clean;
        m_clean = nc;
        raws[n % HN] = sw;
        n++;
    endtask

    // Inputs only change 1 time unit after a falling edge, so at the falling
    // edge sw/rst_n still hold the values the preceding rising edge saw.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            chk("m_clean",  clean,            m_clean);
            chk("m_rise",   rise,             m_rise);
            chk("m_fall",   fall,             m_fall);
            chk("m_stable", {{(W-1){1'b0}}, stable}, {{(W-1){1'b0}}, m_stable});
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_clean",  clean,  '0);
        chk("rst_rise",   rise,   '0);
        chk("rst_fall",   fall,   '0);
        chk("rst_stable", {{(W-1){1'b0}}, stable}, 10'd1);
        chk("rst_clean1", clean1, '0);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single step on bit 0
        #1 sw[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("step_clean0",  {9'd0, clean[0]},  {9'd0, i >= 6});
            chk("step_rise0",   {9'd0, rise[0]},   {9'd0, i == 6});
            chk("step_stable",  {9'd0, stable},    {9'd0, !(i >= 3 && i <= 6)});
        end
        #1 sw[0] = 1'b0;
        repeat (10) @(negedge clk);

        // glitch train on bit 3
        for (int i = 0; i < 20; i++) begin
            #1 sw[3] = (i % 2 == 0);
            @(negedge clk);
            chk("glitch_clean3", {9'd0, clean[3]}, 10'd0);
            chk("glitch_rise3",  {9'd0, rise[3]},  10'd0);
        end
        #1 sw[3] = 1'b0;
        repeat (8) @(negedge clk);

        // all bits together
        #1 sw = '1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("all_clean", clean, (i >= 6) ? 10'h3FF : 10'h000);
            chk("all_rise",  rise,  (i == 6) ? 10'h3FF : 10'h000);
        end
        #1 sw = '0;
        repeat (10) @(negedge clk);

        // reset during a pending 1->0 on bit 9
        #1 sw[9] = 1'b1;
        repeat (8) @(negedge clk);
        chk("r9_accepted", {9'd0, clean[9]}, 10'd1);
        #1 sw[9] = 1'b0;
        repeat (4) @(negedge clk);
        chk("r9_pending", {9'd0, clean[9]}, 10'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("r9_clean",  clean, '0);
        chk("r9_fall",   fall,  '0);
        chk("r9_stable", {9'd0, stable}, 10'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // bit 5: three high samples, one low, then high held
        #1 sw[5] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("restart_clean5", {9'd0, clean[5]}, {9'd0, i >= 10});
            chk("restart_rise5",  {9'd0, rise[5]},  {9'd0, i == 10});
            if (i == 3) #1 sw[5] = 1'b0;
            if (i == 4) #1 sw[5] = 1'b1;
        end
        #1 sw = '0;
        repeat (10) @(negedge clk);

        // switch held high across reset release
        #1 rst_n = 1'b0;
        sw[2] = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("por_clean2", {9'd0, clean[2]}, {9'd0, i >= 6});
            chk("por_rise2",  {9'd0, rise[2]},  {9'd0, i == 6});
        end
        #1 sw = '0;
        repeat (10) @(negedge clk);

        // DEBOUNCE_CYCLES=1 build
        #1 sw1[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("d1_clean1", {9'd0, clean1[1]}, {9'd0, i >= 3});
            chk("d1_rise1",  {9'd0, rise1[1]},  {9'd0, i == 3});
        end

        // random traffic: calm stretches and bouncy bursts, rare resets
        for (int c = 0; c < 3000; c++) begin
            #1;
            for (int b = 0; b < W; b++) begin
                if ((c % 300) < 60) begin
                    if ($urandom_range(0, 1) == 0) sw[b] = ~sw[b];
                end else begin
                    if ($urandom_range(0, 15) == 0) sw[b] = ~sw[b];
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 10, number of switch channels debounced.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required to accept a change; legal range 1 to 2^24.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SW  input  WIDTH  raw, asynchronous, bouncing slide-switch levels.
REQ-006 SW_CLEAN  output  WIDTH  debounced switch levels that feed the downstream mux/LED stage (bit 9 used as select).
REQ-007 SW_RISE  output  WIDTH  one-cycle pulse per bit when SW_CLEAN bit goes 0->1.
REQ-008 SW_FALL  output  WIDTH  one-cycle pulse per bit when SW_CLEAN bit goes 1->0.
REQ-009 STABLE  output  1  high when no channel has a change pending (all counters idle).

Function
REQ-010 Each SW bit SHALL pass through a two-flop synchronizer; the second-stage value is the sampled level S.
REQ-011 Per bit, when S equals SW_CLEAN, the counter SHALL be held at 0 (state IDLE).
REQ-012 Per bit, when S differs from SW_CLEAN, the counter SHALL increment by 1 each cycle (state PENDING).
REQ-013 If S returns to equal SW_CLEAN before the count completes, the counter SHALL return to 0 on that cycle and SW_CLEAN SHALL NOT change (glitch rejected).
REQ-014 On the cycle S has differed for DEBOUNCE_CYCLES consecutive cycles, SW_CLEAN SHALL take S on the next edge and the counter SHALL return to 0.
REQ-015 SW_RISE/SW_FALL SHALL be asserted in the same cycle that SW_CLEAN first shows the new value, for exactly one cycle.
REQ-016 Latency from a clean raw SW step to SW_CLEAN change SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never exceed DEBOUNCE_CYCLES and SHALL NOT wrap.
REQ-018 DEBOUNCE_CYCLES=1 SHALL accept a change after one cycle of disagreement (latency 3).
REQ-019 Channels SHALL be fully independent; simultaneous changes on several bits each follow REQ-011..015 with no interaction.
REQ-020 STABLE SHALL be the registered NOR of all per-bit PENDING flags, delayed one cycle.

Reset
REQ-021 While RESET_N is low: synchronizer flops, SW_CLEAN, SW_RISE, SW_FALL and all counters SHALL be 0; STABLE SHALL be 1.
REQ-022 Reset asserted mid-count SHALL discard the pending change immediately (asynchronously), with no edge pulse.
REQ-023 After reset release, a switch held at 1 SHALL produce SW_CLEAN=1 and one SW_RISE pulse after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-024 Package sw_pkg SHALL hold SW_WIDTH=10, DEFAULT_DEBOUNCE_CYCLES=500000 and the per-bit state enum {IDLE, PENDING}.
REQ-025 One sub-module, debounce_bit (synchronizer, counter, clean flop, edge pulses for one bit), SHALL be instantiated WIDTH times with a generate loop.
REQ-026 Top level SHALL contain only the generate loop and the STABLE register.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, SW=10'h000 then SW[0] 0->1 held -> SW_CLEAN[0]=1 and SW_RISE[0] single pulse exactly 6 cycles later; STABLE low during cycles 3-6.
REQ-028 SW[3] toggles 1-cycle high pulses every 2 cycles for 20 cycles -> SW_CLEAN[3] stays 0, SW_RISE[3] never asserted.
REQ-029 SW=10'h3FF step from 0 -> all ten SW_CLEAN bits and SW_RISE bits assert on the same cycle, 6 cycles after the step.
REQ-030 SW[9] 0->1 accepted, then RESET_N pulsed low 2 cycles into a 1->0 change -> SW_CLEAN=0 immediately, no SW_FALL, STABLE=1.
REQ-031 SW[5] high for 3 sampled cycles then low 1 cycle then high held -> counter restarts; SW_CLEAN[5] rises 4 cycles after the final sampled high, not earlier.
REQ-032 Rebuild with DEBOUNCE_CYCLES=1, SW[1] step -> SW_CLEAN[1] changes 3 cycles after step.
